// File: rtl/data_router_bank.sv
// data_router_bank: banked line buffer routing rows/bank rows/columns into a registered PE window
// Optional feature macro: DATA_ROUTER_STALL_CNT_EN (adds stall_cnt output)
module data_router_bank #(
   parameter int DW   = 32,
   parameter int POY  = 3,
   parameter int BUFW = 32,
   parameter int BUFH = 3,
   parameter int BLKW = 16,
   localparam int BW  = POY  > 1 ? $clog2(POY)  : 1,
   localparam int RW  = BUFH > 1 ? $clog2(BUFH) : 1,
   localparam int CW  = BUFW > 1 ? $clog2(BUFW) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [BW-1:0]          wr_bank,
   input  logic [RW-1:0]          wr_row,
   input  logic [CW-1:0]          wr_col,
   input  logic [DW-1:0]          wr_data,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_mode,
   input  logic [BW-1:0]          cmd_bank,
   input  logic [RW-1:0]          cmd_row,
   input  logic [CW-1:0]          cmd_col,
   input  logic [BLKW-1:0]        blk_len,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [POY*BUFW*DW-1:0] out_data,
   output logic [POY*BUFW-1:0]    out_mask,
`ifdef DATA_ROUTER_STALL_CNT_EN
   output logic [31:0]            stall_cnt,
`endif
   output logic                   blkend,
   output logic                   err
);
   localparam logic [1:0] M_RR = 2'b00, M_BR = 2'b01, M_RP = 2'b10, M_NE = 2'b11;
   logic [DW-1:0] mem [POY][BUFH][BUFW];
   logic [POY*BUFW*DW-1:0] nxt_data;
   logic [POY*BUFW-1:0] nxt_mask;
   logic [BLKW-1:0] cnt, lim_m1;
   logic acc, legal, hit;
   assign cmd_ready = !out_valid || out_ready;
   assign acc = cmd_valid && cmd_ready;
   assign legal = cmd_mode != M_NE && 32'(cmd_row) < BUFH &&
                  (cmd_mode != M_BR || 32'(cmd_bank) < POY) &&
                  (cmd_mode != M_RP || 32'(cmd_col) < BUFW);
   assign lim_m1 = blk_len == '0 ? '0 : blk_len - 1'b1;
   assign hit = cnt >= lim_m1;
   // Load port: storage is never reset; out-of-range writes are dropped
   always_ff @(posedge clk)
      if (wr_en && 32'(wr_bank) < POY && 32'(wr_row) < BUFH && 32'(wr_col) < BUFW)
         mem[wr_bank][wr_row][wr_col] <= wr_data;
   // Next window: selected lanes take the stored word, the rest hold their value
   always_comb begin
      nxt_data = out_data;
      nxt_mask = '0;
      for (int i = 0; i < POY; i++)
         for (int k = 0; k < BUFW; k++)
            if (cmd_mode == M_RR || (cmd_mode == M_BR && cmd_bank == BW'(i)) ||
                (cmd_mode == M_RP && cmd_col == CW'(k))) begin
               nxt_data[(i*BUFW+k)*DW +: DW] = mem[i][cmd_row][k];
               nxt_mask[i*BUFW+k] = 1'b1;
            end
   end
   // Output stage, block counter and error pulse; everything freezes while a beat is stalled
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mask  <= '0;
         blkend    <= 1'b0;
         err       <= 1'b0;
         cnt       <= '0;
      end else if (cmd_ready) begin
         err <= acc && !legal;
         if (acc && legal) begin
            out_valid <= 1'b1;
            out_data  <= nxt_data;
            out_mask  <= nxt_mask;
            blkend    <= hit;
            cnt       <= hit ? '0 : cnt + 1'b1;
         end else begin
            out_valid <= 1'b0;
            blkend    <= 1'b0;
         end
      end else
         err <= 1'b0;
`ifdef DATA_ROUTER_STALL_CNT_EN
   // Saturating count of cycles a beat waits on the consumer
   always_ff @(posedge clk or posedge rst)
      if (rst)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && stall_cnt != '1)
         stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule

// File: doc/data_router_bank.md
Name: data_router_bank

Overview:
- Synthesizable, parametrised successor of the simulation-only data router. Holds POY line-buffer banks of BUFH rows x BUFW words.
- Routes rows, single-bank rows or single columns into a registered POY x BUFW output window. The window feeds the PE array.
- Adds a load port, command valid/ready, output valid/ready with a per-lane update mask, a programmable block-end pulse and error reporting.

Parameters:
- DW, 32, data word width
- POY, 3, number of banks (PE rows)
- BUFW, 32, words per buffer row
- BUFH, 3, rows per bank
- BLKW, 16, width of block-length field and command counter

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- wr_en  in  1  load-port write strobe
- wr_bank  in  BW=$clog2(POY) (min 1)  write bank
- wr_row  in  RW=$clog2(BUFH) (min 1)  write row
- wr_col  in  CW=$clog2(BUFW) (min 1)  write column
- wr_data  in  DW  write word
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_mode  in  2  00 RR (row of all banks), 01 BR (row of one bank), 10 RP (one column of all banks), 11 NE (reserved)
- cmd_bank  in  BW  bank for BR
- cmd_row  in  RW  source row
- cmd_col  in  CW  column for RP
- blk_len  in  BLKW  commands per block; 0 treated as 1
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  POY*BUFW*DW  window, flattened as lane [i][k] at bits ((i*BUFW+k)*DW) +: DW
- out_mask  out  POY*BUFW  1 = lane [i][k] updated by this beat
- blkend  out  1  high with the beat of the last command of a block
- err  out  1  one-cycle pulse on an illegal command

Behaviour:
- Reset (async, active-high): out_valid=0, out_data=0, out_mask=0, blkend=0, err=0, command counter=0. Storage array is not reset; its contents are undefined until written.
- Load port: on posedge with wr_en, mem[wr_bank][wr_row][wr_col] <= wr_data. Out-of-range indices are ignored. Load is independent of the command path.
- Write/read same location same cycle: the read returns the old word.
- cmd_ready = !out_valid || out_ready. This is a single-stage pipeline with full throughput.
- Accepted command (cmd_valid && cmd_ready), latency 1 cycle:
  - RR: every lane [i][k] <= mem[i][row][k]; mask all ones.
  - BR: lanes [bank][*] <= mem[bank][row][*]; other lanes keep their value; mask only bank's row.
  - RP: lanes [i][col] <= mem[i][row][col] for all i; other lanes hold; mask only that column.
- Illegal command: mode NE, or any used index out of range (bank>=POY in BR, row>=BUFH, col>=BUFW in RP).
  - Consumed, with no data/mask change and no beat generated (out_valid goes 0 if the prior beat drained).
  - err pulses 1 cycle; the block counter does not advance.
- Legal accepted command: out_valid<=1, and the counter increments.
  - When counter == max(blk_len,1)-1, blkend<=1 with that beat and the counter wraps to 0.
  - Otherwise blkend<=0.
- Beat handshake: out_valid && out_ready consumes the beat. With no new command, out_valid<=0 and blkend<=0. out_data holds its value after the beat is consumed.
- Stall: out_valid && !out_ready holds out_data, out_mask, blkend and out_valid stable; cmd_ready=0.
- blk_len changes mid-block take effect at the next comparison. If the counter is already >= the new length-1, blkend fires on the next legal command.
- Reset mid-operation discards the pending beat and the counter; storage is retained.

Optional Feature:
- DATA_ROUTER_STALL_CNT_EN
- Defined: adds output port stall_cnt [31:0]. The counter increments every cycle with out_valid && !out_ready, saturates at all ones, and is cleared by rst.
- Undefined: the port and the counter do not exist.

Test Plan:
- POY=3, BUFH=3, BUFW=32, load mem[i][j][k]=100*i+j+k; RR row=2, out_ready=1 -> next cycle out_valid=1, lane[1][5]=107, mask all ones.
- After the RR above, BR bank=2 row=0 -> lanes[2][k]=200+k, lanes[0..1] unchanged at 2+k and 102+k, mask = bank-2 row only.
- RP row=1 col=31 -> lanes[i][31]=100*i+32, all other lanes held, mask has exactly 3 bits set.
- blk_len=4, 10 legal back-to-back commands -> blkend on beats 4 and 8 only. Then blk_len=0 -> blkend on every beat.
- NE command, then BR with bank=3 -> two err pulses, no out_valid, counter unchanged, out_data unchanged.
- out_ready low 5 cycles with a beat pending -> cmd_ready=0, outputs stable. With DATA_ROUTER_STALL_CNT_EN, stall_cnt=5. Assert rst during the stall -> out_valid=0 immediately (async).
